// File: rtl/driver_pkg.sv
// driver_pkg: command table and link constants shared by the LED-driver
// controller and its receive-side emulator.
//   WORD_WIDTH          bits per SIN word (config or GS)
//   GS_WORDS            GS words per segment (8 WRTGS + 1 LATGS)
//   SEG_GCLKS           GCLK pulses per display segment
//   BLANK_GCLKS         GCLK pulses of blanking per segment
//   NO_LAT..FCWRTEN     LAT command codes (SCLK rises seen while LAT is high)
//   drv_state_e         receive-side command FSM states
package driver_pkg;

  localparam int unsigned WORD_WIDTH  = 48;
  localparam int unsigned GS_WORDS    = 9;
  localparam int unsigned SEG_GCLKS   = 512;
  localparam int unsigned BLANK_GCLKS = 72;

  localparam logic [4:0] NO_LAT  = 5'd0;
  localparam logic [4:0] WRTGS   = 5'd1;
  localparam logic [4:0] LATGS   = 5'd3;
  localparam logic [4:0] WRTFC   = 5'd5;
  localparam logic [4:0] FCWRTEN = 5'd15;

  localparam logic [4:0] LAT_CNT_MAX = 5'd31;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StDecode
  } drv_state_e;

  // Saturating increment of the LAT edge counter.
  function automatic logic [4:0] lat_cnt_inc(input logic [4:0] cnt);
    return (cnt == LAT_CNT_MAX) ? cnt : cnt + 5'd1;
  endfunction

endpackage

// File: rtl/pin_sync_edge.sv
// pin_sync_edge: 2-FF synchronizer plus rise/fall detection for one pin.
//   i_clk   sampling clock
//   i_rst   synchronous reset, active-high; clears all sync state to 0
//   i_pin   asynchronous pin input
//   o_sync  synchronized pin level
//   o_rise  one-cycle pulse when the synced level goes 0 -> 1
//   o_fall  one-cycle pulse when the synced level goes 1 -> 0
module pin_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/driver_emulator.sv
// driver_emulator: receive side of the SCLK/GCLK/LAT/SIN LED-driver link for
// one SIN lane. Oversamples the pins on clk_hse, decodes LAT commands by the
// number of SCLK rises seen while LAT is high, holds the config latch and the
// double-buffered GS banks, and counts GCLK pulses per segment.
//   clk_hse         sampling clock (>= 4x SCLK/GCLK)
//   rst             synchronous reset, active-high
//   driver_sclk/gclk/lat/sin  controller pins
//   gs_rd_addr      bank-2 read address
//   gs_rd_dat       bank-2 word, registered, 1-cycle latency; 0 when out of range
//   gs_frame_valid  pulse when LATGS completes
//   conf_dat        last config word accepted by WRTFC
//   conf_valid      pulse when conf_dat updates
//   gclk_count      GCLK rises counted in the previous segment
//   last_cmd        LAT edge count of the most recent command
//   cmd_error       sticky error flag, cleared only by rst
module driver_emulator #(
  parameter int unsigned WORD_WIDTH     = driver_pkg::WORD_WIDTH,
  parameter int unsigned GS_WORDS       = driver_pkg::GS_WORDS,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned GCLK_CNT_WIDTH = 11
) (
  input  logic                      clk_hse,
  input  logic                      rst,
  input  logic                      driver_sclk,
  input  logic                      driver_gclk,
  input  logic                      driver_lat,
  input  logic                      driver_sin,
  input  logic [ADDR_WIDTH-1:0]     gs_rd_addr,
  output logic [WORD_WIDTH-1:0]     gs_rd_dat,
  output logic                      gs_frame_valid,
  output logic [WORD_WIDTH-1:0]     conf_dat,
  output logic                      conf_valid,
  output logic [GCLK_CNT_WIDTH-1:0] gclk_count,
  output logic [4:0]                last_cmd,
  output logic                      cmd_error
);

  import driver_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LastPtr = ADDR_WIDTH'(GS_WORDS - 1);

  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_gclk_sync, w_gclk_rise, w_gclk_fall;
  logic w_lat_sync, w_lat_rise, w_lat_fall;
  logic w_sin_sync, w_sin_rise, w_sin_fall;
  logic w_unused;

  pin_sync_edge u_sync_sclk (
    .i_clk  (clk_hse),
    .i_rst  (rst),
    .i_pin  (driver_sclk),
    .o_sync (w_sclk_sync),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  pin_sync_edge u_sync_gclk (
    .i_clk  (clk_hse),
    .i_rst  (rst),
    .i_pin  (driver_gclk),
    .o_sync (w_gclk_sync),
    .o_rise (w_gclk_rise),
    .o_fall (w_gclk_fall)
  );

  pin_sync_edge u_sync_lat (
    .i_clk  (clk_hse),
    .i_rst  (rst),
    .i_pin  (driver_lat),
    .o_sync (w_lat_sync),
    .o_rise (w_lat_rise),
    .o_fall (w_lat_fall)
  );

  pin_sync_edge u_sync_sin (
    .i_clk  (clk_hse),
    .i_rst  (rst),
    .i_pin  (driver_sin),
    .o_sync (w_sin_sync),
    .o_rise (w_sin_rise),
    .o_fall (w_sin_fall)
  );

  assign w_unused = ^{w_sclk_sync, w_sclk_fall, w_gclk_sync, w_gclk_fall, w_sin_rise, w_sin_fall};

  drv_state_e                r_state;
  logic [WORD_WIDTH-1:0]     r_shift;
  logic [WORD_WIDTH-1:0]     r_bank1 [GS_WORDS];
  logic [WORD_WIDTH-1:0]     r_bank2 [GS_WORDS];
  logic [ADDR_WIDTH-1:0]     r_wr_ptr;
  logic [4:0]                r_lat_cnt;
  logic [4:0]                r_cmd;
  logic                      r_fc_en;
  logic [GCLK_CNT_WIDTH-1:0] r_gclk_cnt;

  logic [WORD_WIDTH-1:0]     r_gs_rd_dat;
  logic                      r_gs_frame_valid;
  logic [WORD_WIDTH-1:0]     r_conf_dat;
  logic                      r_conf_valid;
  logic [GCLK_CNT_WIDTH-1:0] r_gclk_count;
  logic [4:0]                r_last_cmd;
  logic                      r_cmd_error;

  // SIN shift register, MSB first. Shifts on every synced SCLK rise, including
  // one coincident with the LAT fall.
  always_ff @(posedge clk_hse) begin
    if (rst) begin
      r_shift <= '0;
    end else if (w_sclk_rise) begin
      r_shift <= {r_shift[WORD_WIDTH-2:0], w_sin_sync};
    end
  end

  // Command FSM with registered decode outputs, bank storage and GCLK counter.
  always_ff @(posedge clk_hse) begin
    if (rst) begin
      r_state          <= StIdle;
      r_wr_ptr         <= '0;
      r_lat_cnt        <= '0;
      r_cmd            <= '0;
      r_fc_en          <= 1'b0;
      r_gclk_cnt       <= '0;
      r_gs_frame_valid <= 1'b0;
      r_conf_dat       <= '0;
      r_conf_valid     <= 1'b0;
      r_gclk_count     <= '0;
      r_last_cmd       <= '0;
      r_cmd_error      <= 1'b0;
      for (int unsigned i = 0; i < GS_WORDS; i++) begin
        r_bank1[i] <= '0;
        r_bank2[i] <= '0;
      end
    end else begin
      r_gs_frame_valid <= 1'b0;
      r_conf_valid     <= 1'b0;

      if (w_gclk_rise && (r_gclk_cnt != '1)) begin
        r_gclk_cnt <= r_gclk_cnt + 1'b1;
      end

      // A LAT fall sample has synced LAT low, so a coincident SCLK rise is not counted.
      if (w_sclk_rise && w_lat_sync) begin
        r_lat_cnt <= lat_cnt_inc(r_lat_cnt);
      end

      unique case (r_state)
        StIdle: begin
          if (w_lat_rise) begin
            r_state <= StCount;
          end
        end
        StCount: begin
          if (w_lat_fall) begin
            r_state   <= StDecode;
            r_cmd     <= r_lat_cnt;
            r_lat_cnt <= '0;
          end
        end
        StDecode: begin
          r_state    <= StIdle;
          r_last_cmd <= r_cmd;
          case (r_cmd)
            WRTGS: begin
              // The last slot is reserved for the LATGS word.
              if (r_wr_ptr == LastPtr) begin
                r_cmd_error <= 1'b1;
              end else begin
                r_bank1[r_wr_ptr] <= r_shift;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
              end
            end
            LATGS: begin
              r_bank1[r_wr_ptr] <= r_shift;
              // Bank 2 takes bank 1 with the incoming word bypassed in.
              for (int unsigned i = 0; i < GS_WORDS; i++) begin
                r_bank2[i] <= (ADDR_WIDTH'(i) == r_wr_ptr) ? r_shift : r_bank1[i];
              end
              r_wr_ptr         <= '0;
              r_gs_frame_valid <= 1'b1;
              r_gclk_count     <= r_gclk_cnt;
              // A GCLK rise in the decode cycle belongs to the new segment.
              r_gclk_cnt       <= {{(GCLK_CNT_WIDTH-1){1'b0}}, w_gclk_rise};
            end
            FCWRTEN: begin
              r_fc_en <= 1'b1;
            end
            WRTFC: begin
              if (r_fc_en) begin
                r_conf_dat   <= r_shift;
                r_conf_valid <= 1'b1;
                r_fc_en      <= 1'b0;
              end else begin
                r_cmd_error <= 1'b1;
              end
            end
            NO_LAT: begin
              r_cmd_error <= 1'b1;
            end
            default: begin
              r_cmd_error <= 1'b1;
            end
          endcase
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_hse) begin
    if (rst) begin
      r_gs_rd_dat <= '0;
    end else if (gs_rd_addr <= LastPtr) begin
      r_gs_rd_dat <= r_bank2[gs_rd_addr];
    end else begin
      r_gs_rd_dat <= '0;
    end
  end

  assign gs_rd_dat      = r_gs_rd_dat;
  assign gs_frame_valid = r_gs_frame_valid;
  assign conf_dat       = r_conf_dat;
  assign conf_valid     = r_conf_valid;
  assign gclk_count     = r_gclk_count;
  assign last_cmd       = r_last_cmd;
  assign cmd_error      = r_cmd_error;

endmodule

// File: doc/driver_emulator.md
Name: driver_emulator

Overview:
- Synthesizable model of the LED-driver receive side of the SCLK/GCLK/LAT/SIN link, for one SIN lane.
- Oversamples the controller's pin outputs on the fast clock. Decodes LAT commands by the number of SCLK rising edges seen while LAT is high.
- Holds the config latch and double-buffered GS banks, and measures GCLK pulses per segment.
- Used in FPGA loopback self-test and as the controller's verification responder.

Parameters:
- WORD_WIDTH, 48, bits shifted per SIN word (config or GS word)
- GS_WORDS, 9, GS words per segment (8 WRTGS + 1 LATGS)
- ADDR_WIDTH, 4, GS read address width; must be ≥ clog2(GS_WORDS)
- GCLK_CNT_WIDTH, 11, width of the GCLK pulse counter

Ports:
- clk_hse  in  1  sampling clock; must be ≥4x the SCLK/GCLK frequency
- rst  in  1  synchronous reset, active-high
- driver_sclk  in  1  SCLK pin from controller
- driver_gclk  in  1  GCLK pin from controller
- driver_lat  in  1  LAT pin from controller
- driver_sin  in  1  one SIN lane from controller
- gs_rd_addr  in  ADDR_WIDTH  bank-2 read address
- gs_rd_dat  out  WORD_WIDTH  bank-2 word at gs_rd_addr, registered, 1-cycle latency
- gs_frame_valid  out  1  one-cycle pulse when LATGS completes
- conf_dat  out  WORD_WIDTH  last config word accepted by WRTFC
- conf_valid  out  1  one-cycle pulse when conf_dat updates
- gclk_count  out  GCLK_CNT_WIDTH  GCLK rises counted in the previous segment
- last_cmd  out  5  LAT edge count of the most recent command
- cmd_error  out  1  sticky error flag; cleared only by rst

Behaviour:
- Reset:
  - All outputs 0; shift reg, bank1, bank2, wr_ptr, lat_cnt, fc_en, gclk counter and sync regs all 0.
  - Reset mid-command discards the partial command.
- Input sampling:
  - All four pins go through the same 2-FF synchronizer, so they stay mutually aligned.
  - Edges are detected on the synced value versus its previous value.
  - Pin high/low phases <2 clk_hse cycles are out of spec and give undefined results.
- On a synced SCLK rise:
  - shift <= {shift[WORD_WIDTH-2:0], sin}, MSB first.
  - If synced LAT is high in the same sample, lat_cnt <= lat_cnt+1, saturating at 31.
- On a synced LAT fall:
  - Decode lat_cnt, then lat_cnt <= 0; last_cmd <= lat_cnt.
  - An SCLK rise in the same sample as the LAT fall shifts data but is not counted.
- Commands:
  - 1 = WRTGS: bank1[wr_ptr] <= shift; wr_ptr++. If wr_ptr == GS_WORDS-1 beforehand: set cmd_error, no write, no increment.
  - 3 = LATGS: bank1[wr_ptr] <= shift, then bank2 <= bank1 including the new word (same cycle, bypassed); wr_ptr <= 0; gs_frame_valid pulse; gclk_count <= gclk counter; gclk counter <= 0.
  - 15 = FCWRTEN: fc_en <= 1.
  - 5 = WRTFC: if fc_en, conf_dat <= shift, conf_valid pulse, fc_en <= 0; else set cmd_error.
  - Any other count, including 0: set cmd_error, no other state change.
- Latency:
  - Decoded-command outputs update on the 3rd clk_hse rising edge after the edge that first samples LAT low.
  - gs_rd_dat updates 1 cycle after gs_rd_addr.
  - gs_rd_addr ≥ GS_WORDS returns 0.
- GCLK:
  - Each synced GCLK rise increments the counter, saturating at all-ones.
  - A GCLK rise in the same sample as a LATGS decode counts toward the new segment, so the counter becomes 1.
- FSM per command:
  - IDLE (LAT low)
  - → COUNT on synced LAT rise
  - → DECODE on synced LAT fall (1 cycle)
  - → IDLE
- A second FCWRTEN while fc_en is set is legal and has no extra effect.

Decomposition:
- Shared package driver_pkg holds:
  - localparams FCWRTEN=15, WRTFC=5, WRTGS=1, LATGS=3, NO_LAT=0
  - WORD_WIDTH and the segment constants (512, blanking 72)
  - So the controller and this emulator share one command table.
- One natural sub-module, pin_sync_edge:
  - 2-FF sync plus rise/fall detection.
  - One instance per pin; each instance's sync regs reset to 0.

Test Plan:
- LAT high for 15 SCLK, then 48 bits of 48'hA5A5_0F0F_1234 with LAT high on the last 5 → conf_valid single pulse, conf_dat=48'hA5A5_0F0F_1234, cmd_error=0, last_cmd=5.
- WRTFC without a preceding FCWRTEN → conf_valid stays 0, conf_dat stays 0, cmd_error=1.
- 8 WRTGS words 48'h1..48'h8, then LATGS word 48'h9 → one gs_frame_valid; gs_rd_addr=k gives 48'h(k+1) one cycle later for k=0..8; addr 9..15 gives 0.
- Exactly 511 GCLK pulses between two LATGS → gclk_count=511 at the second gs_frame_valid; 3000 pulses → 2047.
- LAT held for 7 SCLK rises → cmd_error=1, last_cmd=7, banks/conf/wr_ptr unchanged; 9 WRTGS before LATGS → error on the 9th, bank2 after LATGS holds the first 8 words plus the LATGS word.
- rst pulsed 1 cycle during the 20th bit of a WRTGS word → all outputs 0 next cycle; a following full FCWRTEN/WRTFC sequence passes as in the first scenario.
